// File: rtl/qsys_rr_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master among NUM_REQ requesters,
// with burst lock and an in-order tag FIFO that steers read responses home.
module qsys_rr_master_arbiter #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REQ     = 4,
  parameter int BURST_SIZE  = 1,
  parameter int MAX_PENDING = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*WIDTH-1:0]      req_writedata,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  output logic [NUM_REQ-1:0]            req_waitrequest,
  output logic [WIDTH-1:0]              req_readdata,
  output logic [NUM_REQ-1:0]            req_readdatavalid,
  output logic [ADDR_WIDTH-1:0]         m_address,
  output logic [WIDTH-1:0]              m_writedata,
  output logic                          m_read,
  output logic                          m_write,
  input  logic [WIDTH-1:0]              m_readdata,
  input  logic                          m_readdatavalid,
  input  logic                          m_waitrequest,
  output logic [$clog2(MAX_PENDING):0]  pending,
  output logic                          err
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = $clog2(MAX_PENDING) + 1;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant, grant_nxt;
  logic [GW-1:0]   last_grant, last_nxt;
  logic [7:0]      beat_cnt, beat_nxt;
  logic            grant_valid;

  logic [NUM_REQ-1:0] active;
  logic [GW-1:0]      scan_idx, scan_grant;
  logic               found;

  logic            g_rd, g_wr, accept, full, push, pop;
  logic [PW-1:0]   head, tail;
  logic [GW-1:0]   tag_mem [MAX_PENDING];

  assign active      = req_read | req_write;
  assign grant_valid = (state == GRANTED);
  assign full        = (pending == CW'(MAX_PENDING));
  assign push        = m_read & ~m_waitrequest;
  assign pop         = m_readdatavalid & (pending != '0);
  assign req_readdata = m_readdata;

  // Rotating priority: the requester after last_grant is looked at first.
  always_comb begin
    scan_idx   = '0;
    scan_grant = last_grant;
    found      = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = GW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && active[scan_idx]) begin
        scan_grant = scan_idx;
        found      = 1'b1;
      end
    end
  end

  // A read that collides with a write from the same requester wins outright.
  always_comb begin
    m_address       = '0;
    m_writedata     = '0;
    m_read          = 1'b0;
    m_write         = 1'b0;
    req_waitrequest = '1;
    g_rd            = 1'b0;
    g_wr            = 1'b0;
    accept          = 1'b0;
    if (grant_valid) begin
      g_rd        = req_read[grant];
      g_wr        = req_write[grant] & ~g_rd;
      m_address   = req_address[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
      m_writedata = req_writedata[int'(grant)*WIDTH +: WIDTH];
      m_read      = g_rd & ~full;
      m_write     = g_wr;
      req_waitrequest[grant] = m_waitrequest | (g_rd & full);
      accept      = (m_read | m_write) & ~m_waitrequest;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last_grant;
    beat_nxt  = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANTED;
          grant_nxt = scan_grant;
          beat_nxt  = 8'(BURST_SIZE);
        end
      end
      GRANTED: begin
        if (!active[grant]) begin
          state_nxt = IDLE;
          last_nxt  = grant;
        end else if (accept) begin
          beat_nxt = beat_cnt - 8'd1;
          if (beat_cnt == 8'd1) begin
            state_nxt = IDLE;
            last_nxt  = grant;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      beat_cnt   <= 8'(BURST_SIZE);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_nxt;
      beat_cnt   <= beat_nxt;
    end
  end

  // Tag FIFO: requester index of every accepted read, retired in order.
  always_ff @(posedge clk) begin
    if (push) tag_mem[tail] <= grant;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      pending <= '0;
      err     <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   pending <= pending + CW'(1);
        2'b01:   pending <= pending - CW'(1);
        default: pending <= pending;
      endcase
      if (m_readdatavalid && pending == '0) err <= 1'b1;
    end
  end

  always_comb begin
    req_readdatavalid = '0;
    if (pop) req_readdatavalid[tag_mem[head]] = 1'b1;
  end

endmodule

// File: tb/tb_qsys_rr_master_arbiter.sv
// Scoreboard bench for qsys_rr_master_arbiter: expected fabric transfers and
// routed responses are queued by the stimulus and retired by a monitor.
module tb_qsys_rr_master_arbiter;
  localparam int W  = 32;
  localparam int AW = 32;
  localparam int NR = 4;
  localparam int BS = 2;
  localparam int MP = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR*AW-1:0]  req_address;
  logic [NR*W-1:0]   req_writedata;
  logic [NR-1:0]     req_read  = '0;
  logic [NR-1:0]     req_write = '0;
  logic [NR-1:0]     req_waitrequest;
  logic [W-1:0]      req_readdata;
  logic [NR-1:0]     req_readdatavalid;
  logic [AW-1:0]     m_address;
  logic [W-1:0]      m_writedata;
  logic              m_read, m_write;
  logic [W-1:0]      m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic              m_waitrequest = 1'b0;
  logic [2:0]        pending;
  logic              err;

  qsys_rr_master_arbiter #(
    .WIDTH(W), .ADDR_WIDTH(AW), .NUM_REQ(NR), .BURST_SIZE(BS), .MAX_PENDING(MP)
  ) dut (
    .clk(clk), .rst(rst),
    .req_address(req_address), .req_writedata(req_writedata),
    .req_read(req_read), .req_write(req_write),
    .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
    .req_readdatavalid(req_readdatavalid),
    .m_address(m_address), .m_writedata(m_writedata),
    .m_read(m_read), .m_write(m_write),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_waitrequest(m_waitrequest),
    .pending(pending), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } xfer_t;

  typedef struct {
    logic [NR-1:0] oh;
    logic [W-1:0]  data;
  } rsp_t;

  xfer_t exp_x_q[$];
  rsp_t  exp_r_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;

  logic          resp_en    = 1'b0;
  logic          force_rdv  = 1'b0;
  logic [W-1:0]  force_data = '0;
  logic          acc_rd_q   = 1'b0;
  logic [AW-1:0] acc_addr_q = '0;

  function automatic logic [AW-1:0] addr_of(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h100;
  endfunction

  function automatic logic [W-1:0] wd_of(input int i);
    return 32'hD000_0000 + 32'(i);
  endfunction

  function automatic logic [W-1:0] rsp_data(input logic [AW-1:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_xfer(input logic wr, input int i, input int n);
    xfer_t e;
    e.wr = wr; e.addr = addr_of(i); e.data = wd_of(i);
    repeat (n) exp_x_q.push_back(e);
  endtask

  task automatic exp_rsp(input int i, input int n);
    rsp_t e;
    e.oh = '0; e.oh[i] = 1'b1; e.data = rsp_data(addr_of(i));
    repeat (n) exp_r_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_cnt < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (acc_cnt < target) chk("acc_timeout", 64'(acc_cnt), 64'(target));
  endtask

  // Monitor: retire fabric-side acceptances and requester-side responses.
  initial begin
    xfer_t ex;
    rsp_t  er;
    forever begin
      @(negedge clk);
      acc_rd_q = 1'b0;
      if (rst && (m_read || m_write) && !m_waitrequest) begin
        acc_cnt++;
        if (m_read) begin
          acc_rd_q   = 1'b1;
          acc_addr_q = m_address;
        end
        if (exp_x_q.size() == 0) begin
          chk("xfer_unexpected", {m_write, m_address}, 64'h0);
        end else begin
          ex = exp_x_q.pop_front();
          chk("xfer_write", 64'(m_write), 64'(ex.wr));
          chk("xfer_read", 64'(m_read), 64'(!ex.wr));
          chk("xfer_addr", 64'(m_address), 64'(ex.addr));
          if (ex.wr) chk("xfer_wdata", 64'(m_writedata), 64'(ex.data));
        end
      end
      if (req_readdatavalid != '0) begin
        if (exp_r_q.size() == 0) begin
          chk("rsp_unexpected", 64'(req_readdatavalid), 64'h0);
        end else begin
          er = exp_r_q.pop_front();
          chk("rsp_onehot", 64'(req_readdatavalid), 64'(er.oh));
          chk("rsp_data", 64'(req_readdata), 64'(er.data));
        end
      end
    end
  end

  // Fabric responder: one-cycle read latency, plus directed injections.
  initial begin
    forever begin
      @(posedge clk); #2;
      m_readdatavalid = force_rdv | (resp_en & acc_rd_q);
      m_readdata      = force_rdv ? force_data : rsp_data(acc_addr_q);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < NR; i++) begin
      req_address[i*AW +: AW]  = addr_of(i);
      req_writedata[i*W +: W]  = wd_of(i);
    end
    force_data = rsp_data(addr_of(0));

    // Reset values
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_m_read", 64'(m_read), 64'h0);
    chk("rst_m_write", 64'(m_write), 64'h0);
    chk("rst_waitreq", 64'(req_waitrequest), 64'hF);
    chk("rst_rdv", 64'(req_readdatavalid), 64'h0);
    chk("rst_pending", 64'(pending), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    @(posedge clk); #1 rst = 1'b1;
    cyc(2);

    // Round robin with 2-beat bursts between requesters 1 and 2
    resp_en = 1'b1;
    base = acc_cnt;
    exp_xfer(1'b0, 1, 2); exp_xfer(1'b0, 2, 2); exp_xfer(1'b0, 1, 2);
    exp_rsp(1, 2); exp_rsp(2, 2); exp_rsp(1, 2);
    req_read = 4'b0110;
    wait_acc(base + 6);
    req_read = '0;
    cyc(4);

    // Tag FIFO fills with no responses, then one response frees a slot
    resp_en = 1'b0;
    base = acc_cnt;
    exp_xfer(1'b0, 0, 4);
    req_read = 4'b0001;
    wait_acc(base + 4);
    cyc(3);
    @(negedge clk);
    chk("full_pending", 64'(pending), 64'd4);
    chk("full_m_read", 64'(m_read), 64'h0);
    chk("full_waitreq", 64'(req_waitrequest), 64'hF);
    @(posedge clk); #1;
    exp_xfer(1'b0, 0, 1);
    exp_rsp(0, 1);
    force_rdv = 1'b1;
    cyc(1);
    force_rdv = 1'b0;
    @(negedge clk);
    chk("pop_pending", 64'(pending), 64'd3);
    @(posedge clk); #1;
    wait_acc(base + 5);
    req_read = '0;
    cyc(1);
    exp_rsp(0, 4);
    force_rdv = 1'b1;
    cyc(4);
    force_rdv = 1'b0;
    cyc(2);
    @(negedge clk);
    chk("drain_pending", 64'(pending), 64'd0);
    @(posedge clk); #1;

    // Read and write together: only the read reaches the fabric
    resp_en = 1'b1;
    base = acc_cnt;
    exp_xfer(1'b0, 0, 2);
    exp_rsp(0, 2);
    req_read = 4'b0001; req_write = 4'b0001;
    wait_acc(base + 2);
    req_read = '0; req_write = '0;
    cyc(4);

    // Fabric stall on the second beat holds grant and address
    base = acc_cnt;
    exp_xfer(1'b0, 3, 2);
    exp_rsp(3, 2);
    req_read = 4'b1000;
    wait_acc(base + 1);
    m_waitrequest = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("stall_addr", 64'(m_address), 64'(addr_of(3)));
      chk("stall_m_read", 64'(m_read), 64'h1);
      chk("stall_waitreq", 64'(req_waitrequest), 64'hF);
      @(posedge clk); #1;
    end
    chk("stall_no_beat", 64'(acc_cnt), 64'(base + 1));
    m_waitrequest = 1'b0;
    wait_acc(base + 2);
    req_read = '0;
    cyc(4);

    // Write-only burst from requester 3
    base = acc_cnt;
    exp_xfer(1'b1, 3, 2);
    req_write = 4'b1000;
    wait_acc(base + 2);
    req_write = '0;
    cyc(3);
    @(negedge clk);
    chk("wr_pending", 64'(pending), 64'd0);
    chk("wr_err", 64'(err), 64'h0);
    chk("wr_idle_waitreq", 64'(req_waitrequest), 64'hF);
    @(posedge clk); #1;

    // Asynchronous reset with two reads outstanding, then a stray response
    resp_en = 1'b0;
    base = acc_cnt;
    exp_xfer(1'b0, 1, 2);
    req_read = 4'b0010;
    wait_acc(base + 2);
    m_waitrequest = 1'b1;
    cyc(2);
    @(negedge clk);
    chk("pre_rst_m_read", 64'(m_read), 64'h1);
    chk("pre_rst_pending", 64'(pending), 64'd2);
    #1 rst = 1'b0;
    #1;
    chk("arst_m_read", 64'(m_read), 64'h0);
    chk("arst_waitreq", 64'(req_waitrequest), 64'hF);
    chk("arst_pending", 64'(pending), 64'h0);
    @(posedge clk); #1;
    req_read = '0;
    m_waitrequest = 1'b0;
    rst = 1'b1;
    cyc(1);
    force_rdv = 1'b1;
    @(negedge clk);
    chk("stray_rdv", 64'(req_readdatavalid), 64'h0);
    chk("stray_err_before", 64'(err), 64'h0);
    @(posedge clk); #1;
    force_rdv = 1'b0;
    @(negedge clk);
    chk("stray_err", 64'(err), 64'h1);
    cyc(3);
    chk("err_sticky", 64'(err), 64'h1);
    chk("xfer_q_empty", 64'(exp_x_q.size()), 64'h0);
    chk("rsp_q_empty", 64'(exp_r_q.size()), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
